// File: rtl/gyruss_audio_pkg.sv
// Shared constants, FSM encoding and the saturation helper for the
// serial high-pass filter datapath.
package gyruss_audio_pkg;

  localparam int ACC_W   = 40;  // accumulator width, wide enough to never wrap
  localparam int COEF_W  = 18;  // multiplier operand width (one 18x18 slice)
  localparam int DATA_W  = 16;  // audio sample width
  localparam int DIV_W   = 10;  // sample divider width
  localparam int Q_SHIFT = 15;  // Q15 coefficients

  localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_B1,
    ST_MUL_B2,
    ST_MUL_A2,
    ST_OUTPUT
  } hpf_state_t;

  // Clamp a wide signed value into the 16-bit sample range.
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    logic signed [DATA_W-1:0] r;
    if (v > SAT_MAX)      r = 16'sh7fff;
    else if (v < SAT_MIN) r = 16'sh8000;
    else                  r = v[DATA_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/gyruss_sample_tick.sv
// Sample-rate tick generator: counts 0..eff_div-1 and pulses tick once
// per period. The divider is latched at each wrap so a change only takes
// effect on the following period.
module gyruss_sample_tick
  import gyruss_audio_pkg::*;
#(
  parameter int DIV_MIN = 5
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic             armed;
  logic [DIV_W-1:0] div_src;
  logic [DIV_W-1:0] eff_div;
  logic             wrap;

  // Until the first wrap there is no latched divider yet, so the very
  // first period after reset follows the live input.
  always_comb begin
    div_src = armed ? div_q : div;
    eff_div = (div_src < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_src;
    wrap    = (cnt == eff_div - DIV_W'(1));
  end

  // Period counter, divider latch and registered tick (high the cycle
  // after the wrap edge, i.e. eff_div clocks after reset release).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      div_q <= '0;
      armed <= 1'b0;
      tick  <= 1'b0;
    end else begin
      tick <= wrap;
      if (wrap) begin
        cnt   <= '0;
        div_q <= div;
        armed <= 1'b1;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/gyruss_hpf_serial.sv
// First-order Q15 high-pass filter, evaluated serially on one shared
// signed 18x18 multiplier:
//   y[n] = sat((B1*x[n] + B2*x[n-1] - A2*y[n-1]) >>> 15)
module gyruss_hpf_serial
  import gyruss_audio_pkg::*;
#(
  parameter int DIV_MIN = 5,
  parameter int COEF_B1 = 32594,
  parameter int COEF_B2 = -32594,
  parameter int COEF_A2 = -32420
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DIV_W-1:0]         div,
  input  logic signed [DATA_W-1:0] in,
  output logic signed [DATA_W-1:0] out,
  output logic                     out_valid
);

  localparam logic signed [COEF_W-1:0] B1 = COEF_W'(COEF_B1);
  localparam logic signed [COEF_W-1:0] B2 = COEF_W'(COEF_B2);
  localparam logic signed [COEF_W-1:0] A2 = COEF_W'(COEF_A2);

  hpf_state_t                state;
  logic                      tick;
  logic signed [DATA_W-1:0]  x_cur;
  logic signed [DATA_W-1:0]  x_prev;
  logic signed [DATA_W-1:0]  y_prev;
  logic signed [ACC_W-1:0]   acc;
  logic signed [COEF_W-1:0]  mul_c;
  logic signed [COEF_W-1:0]  mul_d;
  logic signed [2*COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_shr;
  logic signed [DATA_W-1:0]  y_sat;

  gyruss_sample_tick #(.DIV_MIN(DIV_MIN)) u_tick (
    .clk   (clk),
    .reset (reset),
    .div   (div),
    .tick  (tick)
  );

  // Operand steering for the single multiplier; samples are sign-extended
  // to the 18-bit operand width.
  always_comb begin
    mul_c = '0;
    mul_d = '0;
    unique case (state)
      ST_MUL_B1: begin mul_c = B1; mul_d = {{(COEF_W-DATA_W){x_cur[DATA_W-1]}},  x_cur};  end
      ST_MUL_B2: begin mul_c = B2; mul_d = {{(COEF_W-DATA_W){x_prev[DATA_W-1]}}, x_prev}; end
      ST_MUL_A2: begin mul_c = A2; mul_d = {{(COEF_W-DATA_W){y_prev[DATA_W-1]}}, y_prev}; end
      default:   ;
    endcase
    prod     = mul_c * mul_d;
    prod_ext = {{(ACC_W-2*COEF_W){prod[2*COEF_W-1]}}, prod};
    acc_shr  = acc >>> Q_SHIFT;
    y_sat    = sat16(acc_shr);
  end

  // MAC sequencer: one product per state, result and history committed
  // together in OUTPUT so a reset mid-sequence leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      acc       <= '0;
      x_cur     <= '0;
      x_prev    <= '0;
      y_prev    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        ST_IDLE: if (tick) begin
          x_cur <= in;
          acc   <= '0;
          state <= ST_MUL_B1;
        end
        ST_MUL_B1: begin acc <= acc + prod_ext; state <= ST_MUL_B2; end
        ST_MUL_B2: begin acc <= acc + prod_ext; state <= ST_MUL_A2; end
        ST_MUL_A2: begin acc <= acc - prod_ext; state <= ST_OUTPUT; end
        ST_OUTPUT: begin
          out       <= y_sat;
          y_prev    <= y_sat;
          x_prev    <= x_cur;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
